// File: rtl/spi_ioexp_regfile_if.sv
// SPI serial bus between an external master and the I/O expander slave.
interface spi_ioexp_regfile_if;
    logic ce_n;
    logic sin;
    logic sout;

    modport master (output ce_n, output sin, input sout);
    modport slave  (input ce_n, input sin, output sout);
endinterface

// File: rtl/spi_ioexp_regfile.sv
// SPI I/O expander register file: command byte, auto-incrementing bursts, per-frame input snapshot.
// Optional build macro IOEXP_POLARITY_EN adds an RW POL register that inverts sampled inputs.
module spi_ioexp_regfile #(
    parameter int unsigned NIN       = 3,
    parameter int unsigned NOUT      = 7,
    parameter logic [7:0]  RESET_OUT = 8'h00,
    parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
    input  logic                sclk,
    input  logic                reset,
    spi_ioexp_regfile_if.slave  bus,
    input  logic [NIN-1:0]      inputs,
    output logic [NOUT-1:0]     outputs,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_IN      = 3'd1;
    localparam logic [2:0] ADDR_POL     = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH = 3'd3;
    localparam logic [2:0] ADDR_ID      = 3'd4;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     addr_q, addr_d;
    logic [6:0]     shift_q, shift_d;
    logic [7:0]     tx_q, tx_d;
    logic [7:0]     out_q, out_d;
    logic [7:0]     scratch_q, scratch_d;
    logic [NIN-1:0] snap_q, snap_d;
    logic           rw_q, rw_d;
    logic           busy_q, busy_d;
    logic [7:0]     pol_val;
    logic [NIN-1:0] snap_src;

`ifdef IOEXP_POLARITY_EN
    logic [7:0]     pol_q, pol_d;
    assign pol_val  = pol_q;
    assign snap_src = inputs ^ pol_q[NIN-1:0];
`else
    assign pol_val  = 8'h00;
    assign snap_src = inputs;
`endif

    logic [7:0] wdata;
    logic [2:0] cmd_addr;
    logic [2:0] addr_inc;
    logic [2:0] cnt_inc;
    logic [7:0] rd_cmd;
    logic [7:0] rd_next;

    assign wdata    = {shift_q, bus.sin};
    assign cmd_addr = {shift_q[1:0], bus.sin};
    assign addr_inc = 3'(addr_q + 3'd1);
    assign cnt_inc  = 3'(cnt_q + 3'd1);

    function automatic logic [7:0] reg_read(input logic [2:0] a, input logic [7:0] o,
                                            input logic [7:0] in8, input logic [7:0] po,
                                            input logic [7:0] sc);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            ADDR_OUT:     r = o;
            ADDR_IN:      r = in8;
            ADDR_POL:     r = po;
            ADDR_SCRATCH: r = sc;
            ADDR_ID:      r = ID_VALUE;
            default:      r = 8'h00;
        endcase
        return r;
    endfunction

    assign rd_cmd  = reg_read(cmd_addr, out_q, 8'(snap_q), pol_val, scratch_q);
    assign rd_next = reg_read(addr_inc, out_q, 8'(snap_q), pol_val, scratch_q);

    // State register
    always_ff @(posedge sclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; deasserted chip enable aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (bus.ce_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CMD;
                CMD:     if (cnt_q == 3'd7) state_d = DATA;
                DATA:    state_d = DATA;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and register-file next values
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        out_d     = out_q;
        scratch_d = scratch_q;
        snap_d    = snap_q;
        rw_d      = rw_q;
`ifdef IOEXP_POLARITY_EN
        pol_d     = pol_q;
`endif
        busy_d    = (state_d != IDLE);

        if (bus.ce_n) begin
            cnt_d   = 3'd0;
            shift_d = 7'd0;
            tx_d    = 8'h00;
        end else begin
            shift_d = {shift_q[5:0], bus.sin};
            case (state_q)
                IDLE: begin
                    cnt_d  = 3'd1;
                    snap_d = snap_src;
                    tx_d   = 8'h00;
                end
                CMD: begin
                    cnt_d = cnt_inc;
                    tx_d  = 8'h00;
                    if (cnt_q == 3'd7) begin
                        rw_d   = shift_q[6];
                        addr_d = cmd_addr;
                        cnt_d  = 3'd0;
                        // Preload the first read byte so its MSB is on sout next cycle
                        tx_d   = shift_q[6] ? 8'h00 : rd_cmd;
                    end
                end
                DATA: begin
                    cnt_d = cnt_inc;
                    if (rw_q) begin
                        tx_d = 8'h00;
                        if (cnt_q == 3'd7) begin
                            case (addr_q)
                                ADDR_OUT:     out_d     = wdata;
`ifdef IOEXP_POLARITY_EN
                                ADDR_POL:     pol_d     = wdata;
`endif
                                ADDR_SCRATCH: scratch_d = wdata;
                                default:      ;
                            endcase
                            addr_d = addr_inc;
                        end
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                        if (cnt_q == 3'd7) begin
                            addr_d = addr_inc;
                            tx_d   = rd_next;
                        end
                    end
                end
                default: begin
                    cnt_d = 3'd0;
                    tx_d  = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            cnt_q     <= 3'd0;
            addr_q    <= 3'd0;
            shift_q   <= 7'd0;
            tx_q      <= 8'h00;
            out_q     <= RESET_OUT;
            scratch_q <= 8'h00;
            snap_q    <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef IOEXP_POLARITY_EN
            pol_q     <= 8'h00;
`endif
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            out_q     <= out_d;
            scratch_q <= scratch_d;
            snap_q    <= snap_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
`ifdef IOEXP_POLARITY_EN
            pol_q     <= pol_d;
`endif
        end
    end

    assign bus.sout = tx_q[7];
    assign outputs  = out_q[NOUT-1:0];
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_ioexp_regfile.sv
// Directed bench for spi_ioexp_regfile: SPI master tasks plus hand-computed expected register values.
module tb_spi_ioexp_regfile;

    logic       sclk = 1'b0;
    logic       reset;
    logic [2:0] inputs;
    logic [6:0] outputs;
    logic       busy;
    logic [2:0] inputs2;
    logic [6:0] outputs2;
    logic       busy2;

    int vectors = 0;
    int miscompares = 0;

    spi_ioexp_regfile_if bus();
    spi_ioexp_regfile_if bus2();

    spi_ioexp_regfile #(.NIN(3), .NOUT(7), .RESET_OUT(8'h00), .ID_VALUE(8'hA5)) dut (
        .sclk(sclk), .reset(reset), .bus(bus), .inputs(inputs), .outputs(outputs), .busy(busy)
    );

    spi_ioexp_regfile #(.NIN(3), .NOUT(7), .RESET_OUT(8'h15), .ID_VALUE(8'hA5)) dut2 (
        .sclk(sclk), .reset(reset), .bus(bus2), .inputs(inputs2), .outputs(outputs2), .busy(busy2)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Shift the top n bits of b, MSB first; returns just after the last rising edge
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge sclk);
            bus.ce_n = 1'b0;
            bus.sin  = b[i];
            @(posedge sclk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic read_byte(output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk);
            r[i]    = bus.sout;
            bus.sin = 1'b0;
            @(posedge sclk);
        end
    endtask

    task automatic end_frame();
        @(negedge sclk);
        bus.ce_n = 1'b1;
        bus.sin  = 1'b0;
        @(posedge sclk);
        #1;
    endtask

    logic [7:0] rd;
    logic [7:0] exp_in_pol;
    logic [7:0] exp_pol;

    initial begin
        reset     = 1'b1;
        bus.ce_n  = 1'b1;
        bus.sin   = 1'b0;
        bus2.ce_n = 1'b1;
        bus2.sin  = 1'b0;
        inputs    = 3'b000;
        inputs2   = 3'b000;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        reset = 1'b0;
        repeat (2) @(posedge sclk);
        #1;

        // Reset state
        chk("rst_outputs", 8'(outputs), 8'h00);
        chk("rst_sout", 8'(bus.sout), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_outputs_reset_out15", 8'(outputs2), 8'h15);

        // Single write to OUT lands on the 16th edge
        send_byte(8'h80);
        send_byte(8'h5A);
        #1;
        chk("wr_out_16th_edge", 8'(outputs), 8'h5A);
        chk("busy_in_frame", 8'(busy), 8'h01);
        chk("sout_zero_in_write", 8'(bus.sout), 8'h00);
        end_frame();
        chk("busy_after_frame", 8'(busy), 8'h00);

        // Read back OUT
        send_byte(8'h00);
        read_byte(rd);
        chk("rd_out", rd, 8'h5A);
        end_frame();
        chk("sout_idle", 8'(bus.sout), 8'h00);

        // Burst write SCRATCH then ID (dropped), burst read back
        send_byte(8'h83);
        send_byte(8'h11);
        send_byte(8'h22);
        end_frame();
        send_byte(8'h03);
        read_byte(rd);
        chk("rd_scratch", rd, 8'h11);
        read_byte(rd);
        chk("rd_id_unchanged", rd, 8'hA5);
        end_frame();
        chk("outputs_after_burst", 8'(outputs), 8'h5A);

        // Input snapshot
        inputs = 3'b101;
        send_byte(8'h01);
        read_byte(rd);
        chk("rd_in", rd, 8'h05);
        end_frame();

        // Snapshot held across the frame; nine-byte burst wraps back to IN
        send_byte(8'h01);
        read_byte(rd);
        chk("burst_in_first", rd, 8'h05);
        inputs = 3'b010;
        read_byte(rd);
        chk("burst_pol_default", rd, 8'h00);
        read_byte(rd);
        chk("burst_scratch", rd, 8'h11);
        read_byte(rd);
        chk("burst_id", rd, 8'hA5);
        read_byte(rd);
        chk("burst_addr5", rd, 8'h00);
        read_byte(rd);
        chk("burst_addr6", rd, 8'h00);
        read_byte(rd);
        chk("burst_addr7", rd, 8'h00);
        read_byte(rd);
        chk("burst_wrap_out", rd, 8'h5A);
        read_byte(rd);
        chk("burst_in_again", rd, 8'h05);
        end_frame();

        // Write to unmapped address is dropped
        send_byte(8'h85);
        send_byte(8'hFF);
        end_frame();
        send_byte(8'h05);
        read_byte(rd);
        chk("rd_unmapped", rd, 8'h00);
        end_frame();

        // Abort after 4 data bits leaves OUT untouched
        send_byte(8'h80);
        send_bits(8'hFF, 4);
        end_frame();
        chk("abort_no_write", 8'(outputs), 8'h5A);

        // Reset after the 12th edge of 0x80 0xFF, with ce_n still low
        send_byte(8'h80);
        send_bits(8'hFF, 4);
        @(negedge sclk);
        reset = 1'b1;
        @(posedge sclk);
        #1;
        chk("midframe_reset_outputs", 8'(outputs), 8'h00);
        chk("midframe_reset_busy", 8'(busy), 8'h00);
        chk("midframe_reset_sout", 8'(bus.sout), 8'h00);
        @(negedge sclk);
        reset    = 1'b0;
        bus.ce_n = 1'b1;
        @(posedge sclk);
        #1;
        chk("post_reset_idle_busy", 8'(busy), 8'h00);

        // Polarity: write POL=0x07, then read IN and POL
`ifdef IOEXP_POLARITY_EN
        exp_in_pol = 8'h02;
        exp_pol    = 8'h07;
`else
        exp_in_pol = 8'h05;
        exp_pol    = 8'h00;
`endif
        inputs = 3'b101;
        send_byte(8'h82);
        send_byte(8'h07);
        end_frame();
        send_byte(8'h01);
        read_byte(rd);
        chk("pol_in", rd, exp_in_pol);
        read_byte(rd);
        chk("pol_reg", rd, exp_pol);
        end_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
